// File: rtl/preload_pkg.sv
// Shared types and constants for the data-memory preload sequencer.
package preload_pkg;

  // Controller states, in the order the sequencer walks through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CRST    = 3'd2,
    START   = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5,
    TIMEOUT = 3'd6
  } state_t;

  // Number of cycles the core is held in reset after the image lands.
  localparam int CRST_LEN = 2;

  // Width of the run-cycle counter and its saturation value.
  localparam int          RUN_CNT_W = 32;
  localparam logic [31:0] RUN_MAX   = 32'hFFFF_FFFF;

  // One load beat as seen at the input port (default 8-bit memory geometry).
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } load_beat_t;

endpackage

// File: rtl/run_timer.sv
// Saturating run-cycle counter with a terminal-count flag against TIMEOUT.
// tc fires in the cycle whose increment makes the count equal TIMEOUT, so
// the owner can leave RUN on the same edge the count lands on TIMEOUT.
module run_timer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        tc
);
  import preload_pkg::*;

  logic [RUN_CNT_W-1:0] count_r;
  logic [RUN_CNT_W-1:0] count_s;

  // Next count: increment, but stick at the all-ones value.
  always_comb begin
    count_s = count_r;
    if (count_r == RUN_MAX) begin
      count_s = count_r;
    end else begin
      count_s = count_r + 32'd1;
    end
  end

  // Counter register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (clr) begin
      count_r <= 32'd0;
    end else if (en) begin
      count_r <= count_s;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = en && (TIMEOUT != 32'd0) && (count_s == TIMEOUT);

endmodule

// File: rtl/mem_preload_sequencer.sv
// Preload sequencer: streams (addr,data) beats into the core data memory,
// resets and starts the core, waits for Ack and reports Done / TimedOut
// and the number of run cycles.
// Optional feature: define MEM_PRELOAD_CHECKSUM_EN to add a Checksum output
// carrying the XOR of all words written for the current image.
module mem_preload_sequencer #(
  parameter int          AW        = 8,
  parameter int          DW        = 8,
  parameter int          START_LEN = 2,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [AW-1:0] InAddr,
  input  logic [DW-1:0] InData,
  input  logic          InLast,
  input  logic          Clear,
  output logic          MemWrEn,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWrData,
  output logic          CoreReset,
  output logic          CoreStart,
  input  logic          CoreAck,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
  output logic [31:0]   RunCycles
`ifdef MEM_PRELOAD_CHECKSUM_EN
  ,
  output logic [DW-1:0] Checksum
`endif
);
  import preload_pkg::*;

  state_t        state_r;
  state_t        state_s;
  logic [15:0]   phase_cnt_r;
  logic          accept_s;
  logic          tc_s;
  logic          in_ready_r;
  logic          mem_wr_en_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_data_r;
  logic          core_reset_r;
  logic          core_start_r;
  logic          busy_r;
  logic          done_r;
  logic          timed_out_r;

  assign accept_s = InValid && in_ready_r;

  // Next-state logic for the load / reset / start / run sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = InLast ? CRST : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && InLast) begin
          state_s = CRST;
        end else begin
          state_s = LOAD;
        end
      end
      CRST: begin
        if (phase_cnt_r == 16'(CRST_LEN - 1)) begin
          state_s = START;
        end else begin
          state_s = CRST;
        end
      end
      START: begin
        if (phase_cnt_r == 16'(START_LEN - 1)) begin
          state_s = RUN;
        end else begin
          state_s = START;
        end
      end
      RUN: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (CoreAck) begin
          state_s = DONE;
        end else if (tc_s) begin
          state_s = preload_pkg::TIMEOUT;
        end else begin
          state_s = RUN;
        end
      end
      DONE, preload_pkg::TIMEOUT: begin
        if (Clear) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus the per-phase cycle counter (restarts on every change).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      phase_cnt_r <= 16'd0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        phase_cnt_r <= 16'd0;
      end else begin
        phase_cnt_r <= phase_cnt_r + 16'd1;
      end
    end
  end

  // Control outputs, registered from the next state so they align with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_ready_r   <= 1'b1;
      core_reset_r <= 1'b0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timed_out_r  <= 1'b0;
    end else begin
      in_ready_r   <= (state_s == IDLE) || (state_s == LOAD);
      core_reset_r <= (state_s == CRST);
      core_start_r <= (state_s == START);
      busy_r       <= !((state_s == IDLE) || (state_s == DONE) ||
                        (state_s == preload_pkg::TIMEOUT));
      done_r       <= (state_s == DONE);
      timed_out_r  <= (state_s == preload_pkg::TIMEOUT);
    end
  end

  // Write port register: each accepted beat becomes one write next cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_wr_en_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_data_r  <= '0;
    end else begin
      mem_wr_en_r <= accept_s;
      if (accept_s) begin
        mem_addr_r <= InAddr;
        mem_data_r <= InData;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_data_r <= mem_data_r;
      end
    end
  end

  // The run counter restarts while CoreStart is high and counts every RUN cycle.
  run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (state_r == START),
    .en    (state_r == RUN),
    .count (RunCycles),
    .tc    (tc_s)
  );

`ifdef MEM_PRELOAD_CHECKSUM_EN
  logic [DW-1:0] checksum_r;

  // Running XOR of written words; the first beat of an image restarts it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      checksum_r <= '0;
    end else if (accept_s) begin
      checksum_r <= (state_r == IDLE) ? InData : (checksum_r ^ InData);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign Checksum = checksum_r;
`else
  // Checksum feature not built: no extra state.
`endif

  assign InReady   = in_ready_r;
  assign MemWrEn   = mem_wr_en_r;
  assign MemAddr   = mem_addr_r;
  assign MemWrData = mem_data_r;
  assign CoreReset = core_reset_r;
  assign CoreStart = core_start_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign TimedOut  = timed_out_r;

endmodule

// File: tb/tb_mem_preload_sequencer.sv
// Directed self-checking bench for mem_preload_sequencer (TIMEOUT=50).
// Writes are scoreboarded: each driven beat pushes its expected write and
// the cycle it must appear in; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_preload_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 50;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [AW-1:0] InAddr = '0;
  logic [DW-1:0] InData = '0;
  logic          InLast = 1'b0;
  logic          Clear = 1'b0;
  logic          MemWrEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic          CoreReset;
  logic          CoreStart;
  logic          CoreAck = 1'b0;
  logic          Busy;
  logic          Done;
  logic          TimedOut;
  logic [31:0]   RunCycles;
`ifdef MEM_PRELOAD_CHECKSUM_EN
  logic [DW-1:0] Checksum;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t exp_q[$];

  mem_preload_sequencer #(
    .AW(AW), .DW(DW), .START_LEN(2), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid(InValid), .InReady(InReady), .InAddr(InAddr), .InData(InData),
    .InLast(InLast), .Clear(Clear),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .CoreReset(CoreReset), .CoreStart(CoreStart), .CoreAck(CoreAck),
    .Busy(Busy), .Done(Done), .TimedOut(TimedOut), .RunCycles(RunCycles)
`ifdef MEM_PRELOAD_CHECKSUM_EN
    , .Checksum(Checksum)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding beat.
  always @(negedge Clk) begin : wr_mon
    wr_t e;
    if (Reset_n && MemWrEn) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {31'd0, MemWrEn}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, MemAddr}, {24'd0, e.a});
        chk("wr_data", {24'd0, MemWrData}, {24'd0, e.d});
        chk("wr_latency", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  // Present one beat at a negedge; it is accepted on the next posedge.
  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    chk("in_ready_beat", {31'd0, InReady}, 32'd1);
    InValid = 1'b1;
    InAddr  = a;
    InData  = d;
    InLast  = last;
    exp_q.push_back('{a: a, d: d, c: cyc + 1});
    tick();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  // Called in the first CRST cycle; returns in RUN cycle 1.
  task automatic seq_to_run();
    chk("crst1_reset", {31'd0, CoreReset}, 32'd1);
    chk("crst1_start", {31'd0, CoreStart}, 32'd0);
    chk("crst1_ready", {31'd0, InReady}, 32'd0);
    chk("crst1_busy", {31'd0, Busy}, 32'd1);
    tick();
    chk("crst2_reset", {31'd0, CoreReset}, 32'd1);
    chk("crst2_qempty", exp_q.size(), 32'd0);
    tick();
    chk("start1_reset", {31'd0, CoreReset}, 32'd0);
    chk("start1_start", {31'd0, CoreStart}, 32'd1);
    tick();
    chk("start2_start", {31'd0, CoreStart}, 32'd1);
    tick();
    chk("run1_start", {31'd0, CoreStart}, 32'd0);
    chk("run1_cycles", RunCycles, 32'd0);
    chk("run1_busy", {31'd0, Busy}, 32'd1);
  endtask

  task automatic clear_flags();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_done", {31'd0, Done}, 32'd0);
    chk("clr_timedout", {31'd0, TimedOut}, 32'd0);
    chk("clr_ready", {31'd0, InReady}, 32'd1);
    chk("clr_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, InReady}, 32'd1);
    chk("rst_wren", {31'd0, MemWrEn}, 32'd0);
    chk("rst_corereset", {31'd0, CoreReset}, 32'd0);
    chk("rst_corestart", {31'd0, CoreStart}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_timedout", {31'd0, TimedOut}, 32'd0);
    chk("rst_runcycles", RunCycles, 32'd0);
`ifdef MEM_PRELOAD_CHECKSUM_EN
    chk("rst_checksum", {24'd0, Checksum}, 32'd0);
`endif

    // Three-beat image with a bubble, core acks in RUN cycle 40.
    beat(8'h00, 8'h11, 1'b0);
    beat(8'h01, 8'h22, 1'b0);
    tick();
    beat(8'h02, 8'h33, 1'b1);
    seq_to_run();
    repeat (39) tick();
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("ack40_done", {31'd0, Done}, 32'd1);
    chk("ack40_timedout", {31'd0, TimedOut}, 32'd0);
    chk("ack40_cycles", RunCycles, 32'd40);
    chk("ack40_busy", {31'd0, Busy}, 32'd0);
    chk("ack40_ready", {31'd0, InReady}, 32'd0);
    repeat (3) tick();
    chk("done_sticky", {31'd0, Done}, 32'd1);
    chk("done_cycles_held", RunCycles, 32'd40);
    clear_flags();

    // Timeout: core never acks; Clear during LOAD is ignored.
    Clear = 1'b1;
    beat(8'h10, 8'hA5, 1'b0);
    Clear = 1'b0;
    chk("load_clear_ignored", {31'd0, InReady}, 32'd1);
    beat(8'h11, 8'h5A, 1'b1);
    seq_to_run();
    repeat (49) tick();
    chk("pre_tmo_flag", {31'd0, TimedOut}, 32'd0);
    chk("pre_tmo_cycles", RunCycles, 32'd49);
    tick();
    chk("tmo_flag", {31'd0, TimedOut}, 32'd1);
    chk("tmo_cycles", RunCycles, 32'd50);
    chk("tmo_done", {31'd0, Done}, 32'd0);
    chk("tmo_busy", {31'd0, Busy}, 32'd0);
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("tmo_ack_ignored", {31'd0, Done}, 32'd0);
    chk("tmo_sticky", {31'd0, TimedOut}, 32'd1);
    clear_flags();

    // Ack in the same cycle the count reaches TIMEOUT: Ack wins.
    beat(8'h20, 8'h77, 1'b1);
    seq_to_run();
    repeat (49) tick();
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("tie_done", {31'd0, Done}, 32'd1);
    chk("tie_timedout", {31'd0, TimedOut}, 32'd0);
    chk("tie_cycles", RunCycles, 32'd50);
    clear_flags();

    // Reset_n asserted while the 2nd of 4 beats is on the bus.
    beat(8'h30, 8'h01, 1'b0);
    chk("pre_rst_wren", {31'd0, MemWrEn}, 32'd1);
    InValid = 1'b1;
    InAddr  = 8'h31;
    InData  = 8'h02;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", {31'd0, MemWrEn}, 32'd0);
    chk("mid_rst_ready", {31'd0, InReady}, 32'd1);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_corereset", {31'd0, CoreReset}, 32'd0);
    InValid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst_qempty", exp_q.size(), 32'd0);
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);

    // Single-beat image goes straight to CRST.
    beat(8'h40, 8'h99, 1'b1);
    seq_to_run();
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("single_done", {31'd0, Done}, 32'd1);
    chk("single_cycles", RunCycles, 32'd1);
    clear_flags();

`ifdef MEM_PRELOAD_CHECKSUM_EN
    // Checksum over 0x0F ^ 0xF0 ^ 0x55.
    beat(8'h50, 8'h0F, 1'b0);
    beat(8'h51, 8'hF0, 1'b0);
    beat(8'h52, 8'h55, 1'b1);
    seq_to_run();
    CoreAck = 1'b1;
    tick();
    CoreAck = 1'b0;
    chk("cks_done", {31'd0, Done}, 32'd1);
    chk("cks_value", {24'd0, Checksum}, 32'h0000_00AA);
    clear_flags();
`endif

    tick();
    chk("final_qempty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
